// File: rtl/fifo_rd_serializer.sv
// Pops words from a FIFO read port (1-cycle read latency) and streams them out
// bit-serially over a valid/ready handshake, counting completed words.
module fifo_rd_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd,
    input  logic                  ser_ready,
    output logic                  ser_valid,
    output logic                  ser_bit,
    output logic                  ser_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_sent
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bitcnt;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  is_last;
    logic                  xfer;

    assign is_last    = (bitcnt == LAST_IDX);
    assign xfer       = (state == SHIFT) && ser_ready;
    assign words_sent = cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = fifo_empty ? IDLE : LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT: begin
                if (xfer && is_last) state_nxt = fifo_empty ? IDLE : LOAD;
                else                 state_nxt = SHIFT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs forced to their reset values while resetn is low, even before
    // the first clock edge has cleared the state register.
    always_comb begin
        fifo_rd   = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_last  = 1'b0;
        busy      = 1'b0;
        if (resetn) begin
            case (state)
                IDLE: fifo_rd = !fifo_empty;
                LOAD: busy    = 1'b1;
                SHIFT: begin
                    busy      = 1'b1;
                    ser_valid = 1'b1;
                    ser_bit   = LSB_FIRST ? shreg[0] : shreg[DATA_WIDTH-1];
                    ser_last  = is_last;
                    fifo_rd   = ser_ready && is_last && !fifo_empty;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg  <= '0;
            bitcnt <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shreg  <= fifo_dout;
                    bitcnt <= '0;
                end
                SHIFT: begin
                    if (xfer) begin
                        if (!is_last) begin
                            shreg  <= LSB_FIRST ? {1'b0, shreg[DATA_WIDTH-1:1]}
                                                : {shreg[DATA_WIDTH-2:0], 1'b0};
                            bitcnt <= bitcnt + BW'(1);
                        end else begin
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench: a MSB-first instance and an LSB-first instance with a 2-bit
// word counter share one FIFO model and serial sink.
module tb_fifo_rd_serializer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       ser_ready;
    logic       rd0, rd1, v0, v1, b0, b1, l0, l1, busy0, busy1;
    logic [15:0] ws0;
    logic [1:0]  ws1;

    always #5 clk = ~clk;

    fifo_rd_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .CNT_WIDTH(16)) u0 (
        .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(rd0), .ser_ready(ser_ready), .ser_valid(v0), .ser_bit(b0),
        .ser_last(l0), .busy(busy0), .words_sent(ws0));

    fifo_rd_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .CNT_WIDTH(2)) u1 (
        .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(rd1), .ser_ready(ser_ready), .ser_valid(v1), .ser_bit(b1),
        .ser_last(l1), .busy(busy1), .words_sent(ws1));

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_msb;   // transmission order, first bit in [7]
        logic [7:0] exp_lsb;
    } vec_t;

    vec_t tbl [6];

    int         n_cmp = 0;
    int         n_err = 0;
    int         viol  = 0;
    int         cyc_n = 0;
    logic [7:0] fq [$];
    bit         bits0 [$];
    bit         bits1 [$];
    int         lasts [$];
    int         rd_cyc [$];
    bit         prev_stall = 0;
    logic       pb0, pb1, pl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc();
        logic [7:0] popw;
        bit         have;
        have = 0;
        popw = '0;
        fifo_empty = (fq.size() == 0);
        #1;
        if ((rd0 && fifo_empty) || (rd0 !== rd1) || (v0 !== v1)) viol++;
        if (prev_stall && (!v0 || b0 !== pb0 || b1 !== pb1 || l0 !== pl)) viol++;
        prev_stall = v0 && !ser_ready;
        pb0 = b0; pb1 = b1; pl = l0;
        if (v0 && ser_ready) begin
            bits0.push_back(b0);
            bits1.push_back(b1);
            if (l0) lasts.push_back(bits0.size() - 1);
        end
        if (rd0 && fq.size() != 0) begin
            rd_cyc.push_back(cyc_n);
            popw = fq.pop_front();
            have = 1;
        end
        @(posedge clk);
        #1;
        if (have) fifo_dout = popw;
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run(input int nbits, input int budget, input bit rnd);
        int b;
        b = budget;
        while (bits0.size() < nbits && b > 0) begin
            if (rnd) ser_ready = 1'($urandom_range(0, 1));
            cyc();
            b--;
        end
        ser_ready = 1'b1;
        chk("bits_within_budget", 32'(bits0.size() >= nbits), 1);
        cyc();
    endtask

    task automatic clear();
        bits0.delete(); bits1.delete(); lasts.delete(); rd_cyc.delete();
        viol = 0;
    endtask

    function automatic logic [7:0] seq(input int base, input bit which);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[7-i] = which ? bits1[base+i] : bits0[base+i];
        return s;
    endfunction

    initial begin
        int expw;
        tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
        tbl[1] = '{8'h01, 8'h01, 8'h80};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{8'h00, 8'h00, 8'h00};
        tbl[4] = '{8'h3C, 8'h3C, 8'h3C};
        tbl[5] = '{8'h96, 8'h96, 8'h69};

        resetn = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; ser_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("in_reset_valid", 32'(v0), 0);
        chk("in_reset_busy",  32'(busy0), 0);
        chk("in_reset_rd",    32'(rd0), 0);
        cyc(); cyc();
        chk("reset_ws0", 32'(ws0), 0);
        resetn = 1'b1;

        // Idle with an empty FIFO
        clear();
        for (int i = 0; i < 10; i++) cyc();
        chk("empty_rd_pulses", rd_cyc.size(), 0);
        chk("empty_valid", 32'(v0), 0);
        chk("empty_busy",  32'(busy0), 0);
        chk("empty_ws0",   32'(ws0), 0);

        // Isolated single words
        expw = 0;
        for (int t = 0; t < 2; t++) begin
            clear();
            fq.push_back(tbl[t].word);
            run(8, 40, 0);
            expw++;
            chk($sformatf("w%0d_msb_seq", t), seq(0, 0), tbl[t].exp_msb);
            chk($sformatf("w%0d_lsb_seq", t), seq(0, 1), tbl[t].exp_lsb);
            chk($sformatf("w%0d_last_cnt", t), lasts.size(), 1);
            chk($sformatf("w%0d_last_pos", t), (lasts.size() == 1) ? lasts[0] : 99, 7);
            chk($sformatf("w%0d_rd_pulses", t), rd_cyc.size(), 1);
            chk($sformatf("w%0d_ws0", t), 32'(ws0), expw);
            chk($sformatf("w%0d_ws1", t), 32'(ws1), expw % 4);
            chk($sformatf("w%0d_idle", t), 32'(busy0), 0);
            chk($sformatf("w%0d_protocol", t), viol, 0);
        end

        // Back-to-back words; the 2-bit counter wraps through zero here
        clear();
        for (int t = 2; t < 5; t++) fq.push_back(tbl[t].word);
        run(24, 120, 0);
        expw += 3;
        for (int t = 2; t < 5; t++) begin
            chk($sformatf("b2b%0d_msb_seq", t), seq((t - 2) * 8, 0), tbl[t].exp_msb);
            chk($sformatf("b2b%0d_lsb_seq", t), seq((t - 2) * 8, 1), tbl[t].exp_lsb);
            chk($sformatf("b2b%0d_last_pos", t),
                (lasts.size() > t - 2) ? lasts[t-2] : 99, (t - 2) * 8 + 7);
        end
        chk("b2b_rd_pulses", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3) begin
            chk("b2b_gap1", rd_cyc[1] - rd_cyc[0], 9);
            chk("b2b_gap2", rd_cyc[2] - rd_cyc[1], 9);
        end
        chk("b2b_ws0", 32'(ws0), 5);
        chk("b2b_ws1_wrapped", 32'(ws1), 1);
        chk("b2b_protocol", viol, 0);

        // Random backpressure
        clear();
        fq.push_back(tbl[5].word);
        run(8, 200, 1);
        chk("stall_msb_seq", seq(0, 0), tbl[5].exp_msb);
        chk("stall_lsb_seq", seq(0, 1), tbl[5].exp_lsb);
        chk("stall_rd_pulses", rd_cyc.size(), 1);
        chk("stall_ws0", 32'(ws0), 6);
        chk("stall_ws1", 32'(ws1), 2);
        chk("stall_protocol", viol, 0);

        // Reset after the third bit of a word
        clear();
        fq.push_back(tbl[0].word);
        for (int i = 0; i < 40 && bits0.size() < 3; i++) cyc();
        chk("pre_reset_bits", bits0.size(), 3);
        resetn = 1'b0;
        #1;
        chk("mid_reset_valid", 32'(v0), 0);
        chk("mid_reset_rd", 32'(rd0), 0);
        cyc();
        resetn = 1'b1;
        prev_stall = 0;
        chk("post_reset_valid", 32'(v0), 0);
        chk("post_reset_busy", 32'(busy0), 0);
        chk("post_reset_bit", 32'(b0), 0);
        chk("post_reset_last", 32'(l0), 0);
        chk("post_reset_ws0", 32'(ws0), 0);
        chk("post_reset_ws1", 32'(ws1), 0);
        for (int i = 0; i < 5; i++) cyc();
        chk("abandoned_no_bits", bits0.size(), 3);
        chk("abandoned_no_rd", rd_cyc.size(), 1);
        clear();
        fq.push_back(tbl[1].word);
        run(8, 40, 0);
        chk("restart_msb_seq", seq(0, 0), tbl[1].exp_msb);
        chk("restart_lsb_seq", seq(0, 1), tbl[1].exp_lsb);
        chk("restart_ws0", 32'(ws0), 1);
        chk("restart_ws1", 32'(ws1), 1);
        chk("restart_protocol", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
